dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single data-memory port (`daddr`/`drdata`/`dwdata`/`dwe`) between the CPU load/store path (port A) and a second master such as a memory loader/dump engine (port B). Round-robin between the ports, with a bounded burst lock per owner. Read data is returned on a registered response one cycle after acceptance. Sits between the requesters and `dmem`, which has a combinational read and byte-lane writes on `clk`.

---
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin, burst-limited two-port arbiter in front of dmem with
//            registered per-port read responses. Optional macro
//            DMEM_ARB_STATS_EN builds saturating accepted-beat counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [3:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [3:0]    b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] dwdata,
    output logic [3:0]    dwe,
    input  logic [DW-1:0] drdata,
    output logic [15:0]   cnt_a,
    output logic [15:0]   cnt_b
);

    localparam int c_BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_MAX = c_BURST_W'(MAX_BURST);
    localparam logic [c_BURST_W-1:0] c_ONE = c_BURST_W'(1);

    localparam logic [1:0] c_OWN_IDLE = 2'd0;
    localparam logic [1:0] c_OWN_A    = 2'd1;
    localparam logic [1:0] c_OWN_B    = 2'd2;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    logic [1:0]           r_owner;
    logic [1:0]           w_owner_nxt;
    logic [c_BURST_W-1:0] r_burst;
    logic [c_BURST_W-1:0] w_burst_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic                 w_gnt_a;
    logic                 w_gnt_b;

    logic                 r_a_rvalid;
    logic                 r_b_rvalid;
    logic [DW-1:0]        r_a_rdata;
    logic [DW-1:0]        r_b_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner <= c_OWN_IDLE;
            r_burst <= c_ONE;
            r_last  <= c_PORT_B;
        end else begin
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_owner_nxt = c_OWN_IDLE;
        w_burst_nxt = c_ONE;
        w_last_nxt  = r_last;
        if (w_gnt_a) begin
            w_owner_nxt = c_OWN_A;
            w_last_nxt  = c_PORT_A;
            if (r_owner == c_OWN_A) begin
                w_burst_nxt = (r_burst == c_MAX) ? c_MAX : r_burst + c_ONE;
            end
        end else if (w_gnt_b) begin
            w_owner_nxt = c_OWN_B;
            w_last_nxt  = c_PORT_B;
            if (r_owner == c_OWN_B) begin
                w_burst_nxt = (r_burst == c_MAX) ? c_MAX : r_burst + c_ONE;
            end
        end
    end

    // Grant decision and memory-port mux; everything is forced to 0 in reset
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (reset) begin
            if (a_req && b_req) begin
                case (r_owner)
                    c_OWN_A: begin
                        if (r_burst < c_MAX) w_gnt_a = 1'b1;
                        else                 w_gnt_b = 1'b1;
                    end
                    c_OWN_B: begin
                        if (r_burst < c_MAX) w_gnt_b = 1'b1;
                        else                 w_gnt_a = 1'b1;
                    end
                    default: begin
                        if (r_last == c_PORT_B) w_gnt_a = 1'b1;
                        else                    w_gnt_b = 1'b1;
                    end
                endcase
            end else begin
                w_gnt_a = a_req;
                w_gnt_b = b_req;
            end
        end

        daddr  = '0;
        dwdata = '0;
        dwe    = 4'h0;
        if (w_gnt_a) begin
            daddr  = a_addr;
            dwdata = a_wdata;
            dwe    = a_we;
        end else if (w_gnt_b) begin
            daddr  = b_addr;
            dwdata = b_wdata;
            dwe    = b_we;
        end
    end

    assign a_gnt = w_gnt_a;
    assign b_gnt = w_gnt_b;

    // drdata only ever reaches a register, never an output directly
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_gnt_a;
            r_b_rvalid <= w_gnt_b;
            r_a_rdata  <= (w_gnt_a && (a_we == 4'h0)) ? drdata : '0;
            r_b_rdata  <= (w_gnt_b && (b_we == 4'h0)) ? drdata : '0;
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_a <= 16'h0000;
            r_cnt_b <= 16'h0000;
        end else begin
            if (w_gnt_a && (r_cnt_a != 16'hFFFF)) r_cnt_a <= r_cnt_a + 16'd1;
            if (w_gnt_b && (r_cnt_b != 16'hFFFF)) r_cnt_b <= r_cnt_b + 16'd1;
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
`else
    assign cnt_a = 16'h0000;
    assign cnt_b = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural dmem,
//            reference arbitration model and per-port response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [3:0]    a_we = 4'h0, b_we = 4'h0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [3:0]    dwe;
    logic [DW-1:0] drdata;
    logic [15:0]   cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, byte-lane writes on clk
    logic [31:0] env_mem [0:63];
    logic [31:0] ref_mem [0:63];

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dwe[k]) env_mem[daddr[7:2]][8*k +: 8] <= dwdata[8*k +: 8];
        end
    end

    assign drdata = env_mem[daddr[7:2]];

    // Reference arbitration state: owner 0=idle 1=A 2=B, last 1=A 2=B
    int m_owner = 0;
    int m_burst = 1;
    int m_last  = 2;
    int m_pred  = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    function automatic int predict(input logic rst_n, input logic ar, input logic br);
        if (!rst_n) return 0;
        if (ar && !br) return 1;
        if (br && !ar) return 2;
        if (!ar && !br) return 0;
        if (m_owner != 0) return (m_burst < MAX_BURST) ? m_owner : 3 - m_owner;
        return 3 - m_last;
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
        if (!STATS) return 16'h0;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // Scoreboard: push expected responses at acceptance, pop when they are due
    always begin
        @(negedge clk);
        m_pred = predict(reset, a_req, b_req);
        vectors++;
        if (a_gnt !== (m_pred == 1) || b_gnt !== (m_pred == 2)) begin
            miscompares++;
            $display("FAIL grant: a_gnt=%b b_gnt=%b, required port %0d (0=none 1=A 2=B)",
                     a_gnt, b_gnt, m_pred);
        end
        if (m_pred == 1) begin
            qa.push_back((a_we == 4'h0) ? ref_mem[a_addr[7:2]] : 32'h0);
            for (int k = 0; k < 4; k++)
                if (a_we[k]) ref_mem[a_addr[7:2]][8*k +: 8] = a_wdata[8*k +: 8];
            exp_cnt_a++;
        end else if (m_pred == 2) begin
            qb.push_back((b_we == 4'h0) ? ref_mem[b_addr[7:2]] : 32'h0);
            for (int k = 0; k < 4; k++)
                if (b_we[k]) ref_mem[b_addr[7:2]][8*k +: 8] = b_wdata[8*k +: 8];
            exp_cnt_b++;
        end

        @(posedge clk);
        if (!reset) begin
            qa.delete();
            qb.delete();
            m_owner = 0; m_burst = 1; m_last = 2;
            exp_cnt_a = 0; exp_cnt_b = 0;
        end else if (m_pred != 0) begin
            m_burst = (m_pred == m_owner) ? ((m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1) : 1;
            m_owner = m_pred;
            m_last  = m_pred;
        end else begin
            m_owner = 0;
            m_burst = 1;
        end

        #2;
        vectors++;
        if (qa.size() != 0) begin
            logic [31:0] e;
            e = qa.pop_front();
            if (a_rvalid !== 1'b1 || a_rdata !== e) begin
                miscompares++;
                $display("FAIL a_resp: rvalid=%b rdata=%h, required rvalid=1 rdata=%h", a_rvalid, a_rdata, e);
            end
        end else if (a_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL a_resp: rvalid=%b, required 0", a_rvalid);
        end
        vectors++;
        if (qb.size() != 0) begin
            logic [31:0] e;
            e = qb.pop_front();
            if (b_rvalid !== 1'b1 || b_rdata !== e) begin
                miscompares++;
                $display("FAIL b_resp: rvalid=%b rdata=%h, required rvalid=1 rdata=%h", b_rvalid, b_rdata, e);
            end
        end else if (b_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b_resp: rvalid=%b, required 0", b_rvalid);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        a_req = 1'b1; a_we = 4'hF; a_addr = 32'h40; a_wdata = 32'h12345678;
        b_req = 1'b1; b_we = 4'h0; b_addr = 32'h44; b_wdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || dwe !== 4'h0 || daddr !== '0 || dwdata !== '0) begin
                miscompares++;
                $display("FAIL reset_gate: gnt=%b%b dwe=%h daddr=%h dwdata=%h, required all 0",
                         a_gnt, b_gnt, dwe, daddr, dwdata);
            end
            vectors++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== '0 || cnt_a !== 16'h0 || cnt_b !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_state: rvalid=%b%b rdata=%h cnt=%h/%h, required 0",
                         a_rvalid, b_rvalid, a_rdata, cnt_a, cnt_b);
            end
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL first_tie: a_gnt=%b b_gnt=%b, required A", a_gnt, b_gnt);
        end
        tick();
        idle_ports();
        tick();
    endtask

    task automatic test_write_read;
        a_req = 1'b1; a_we = 4'hF; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        tick();
        a_we = 4'h0;
        vectors++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL write_resp: rvalid=%b rdata=%h, required 1/00000000", a_rvalid, a_rdata);
        end
        tick();
        idle_ports();
        vectors++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL read_back: rvalid=%b rdata=%h, required 1/deadbeef", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_byte_write;
        a_req = 1'b1; a_we = 4'b0010; a_addr = 32'h10; a_wdata = 32'h0000AB00;
        tick();
        a_we = 4'h0;
        tick();
        idle_ports();
        vectors++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADABEF) begin
            miscompares++;
            $display("FAIL byte_lane: rvalid=%b rdata=%h, required 1/deadabef", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_tie_after_a;
        a_req = 1'b1; a_we = 4'h0; a_addr = 32'h10;
        tick();
        idle_ports();
        tick();
        a_req = 1'b1; b_req = 1'b1;
        b_we = 4'h0; b_addr = 32'h10;
        @(negedge clk);
        vectors++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_after_a: a_gnt=%b b_gnt=%b, required B", a_gnt, b_gnt);
        end
        tick();
        idle_ports();
        tick();
    endtask

    task automatic test_round_robin;
        a_req = 1'b1; a_we = 4'h0; a_addr = 32'h10;
        b_req = 1'b1; b_we = 4'hF; b_addr = 32'h20; b_wdata = 32'h0BADF00D;
        for (int i = 0; i < 16; i++) begin
            logic exp_a;
            exp_a = ((i / MAX_BURST) % 2) == 0;
            @(negedge clk);
            vectors++;
            if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
                miscompares++;
                $display("FAIL rr_beat%0d: a_gnt=%b b_gnt=%b, required a_gnt=%b", i, a_gnt, b_gnt, exp_a);
            end
            tick();
        end
        idle_ports();
        tick();
    endtask

    task automatic test_reset_midstream;
        a_req = 1'b1; a_we = 4'h0; a_addr = 32'h20;
        b_req = 1'b1; b_we = 4'h0; b_addr = 32'h10;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || dwe !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset_gate: gnt=%b%b dwe=%h, required 0", a_gnt, b_gnt, dwe);
        end
        tick();
        reset = 1'b1;
        vectors++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || cnt_a !== 16'h0 || cnt_b !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset_state: rvalid=%b%b cnt=%h/%h, required 0", a_rvalid, b_rvalid, cnt_a, cnt_b);
        end
        @(negedge clk);
        vectors++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_after_reset: a_gnt=%b b_gnt=%b, required A", a_gnt, b_gnt);
        end
        tick();
        idle_ports();
        tick();
    endtask

    task automatic test_counters;
        int n;
        n = STATS ? 70000 : 20;
        a_req = 1'b1; a_we = 4'h0; a_addr = 32'h10;
        b_req = 1'b0;
        repeat (n) tick();
        idle_ports();
        tick();
        vectors++;
        if (cnt_a !== exp_cnt(exp_cnt_a) || cnt_b !== exp_cnt(exp_cnt_b)) begin
            miscompares++;
            $display("FAIL counters: cnt_a=%h cnt_b=%h, required %h/%h",
                     cnt_a, cnt_b, exp_cnt(exp_cnt_a), exp_cnt(exp_cnt_b));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_tie_after_a();
        test_round_robin();
        test_reset_midstream();
        test_counters();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
